// File: rtl/pad_arb_pkg.sv
// Shared definitions for pad direction arbiters: controller state encoding,
// parameter limits and the round-robin winner pick used when a pad is idle.
package pad_arb_pkg;

  localparam int NREQ_MIN     = 2;
  localparam int NREQ_MAX     = 8;
  localparam int IDX_W        = 3;
  localparam int TURN_CYC_MIN = 1;
  localparam int TURN_CYC_MAX = 15;
  localparam int CNT_W        = 4;
  localparam int SYNC_STG_MIN = 2;
  localparam int SYNC_STG_MAX = 3;

  typedef enum logic [2:0] {
    IDLE,
    TURN_IN,
    OWN,
    TURN_DIR,
    TURN_OUT
  } arb_state_t;

  // First requester at or after ptr, wrapping modulo n. Only meaningful when
  // at least one of the low n request bits is set; returns ptr otherwise.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ_MAX-1:0] reqs,
                                               input logic [IDX_W-1:0]    ptr,
                                               input int                  n);
    int               slot;
    logic [IDX_W-1:0] sidx;
    rr_pick = ptr;
    // Walk from the farthest slot back to ptr so the nearest hit wins.
    for (int k = NREQ_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        slot = int'(ptr) + k;
        if (slot >= n) slot = slot - n;
        sidx = IDX_W'(slot);
        if (reqs[sidx]) rr_pick = sidx;
      end
    end
  endfunction

endpackage

// File: rtl/pad_in_sync.sv
// Enabled multi-stage synchronizer for a pad input. The chain shifts only
// while en is high and holds otherwise, so a floating pad input cannot ripple
// through to the consumer. q is the last stage.
module pad_in_sync #(
  parameter int STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  logic [STG-1:0] stg;

  // Shift the sampled pad value toward q while the input buffer is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the chain is reset (not left to power-up) so q leaves reset at a known 0.
      stg <= '0;
    end else if (en) begin
      stg <= {stg[STG-2:0], d};
    end
  end

  assign q = stg[STG-1];

endmodule

// File: rtl/pad_dir_arb.sv
// Direction arbiter for one shared bidirectional pad. Grants ownership
// round-robin among NREQ functions and keeps the pad driver off for TURN_CYC
// cycles between owners and on every input-to-output turnaround, so two
// drivers never overlap. The pad input is synchronized back to the owner.
// Optional ownership timeout: define PAD_DIR_ARB_TIMEOUT_EN to add parameter
// MAX_OWN and output timeout_pulse; without it ownership is unbounded.
module pad_dir_arb
  import pad_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int TURN_CYC = 2,
  parameter int SYNC_STG = 2
`ifdef PAD_DIR_ARB_TIMEOUT_EN
  ,
  parameter int MAX_OWN  = 256
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] oe_req,
  input  logic [NREQ-1:0] od_in,
  output logic [NREQ-1:0] grant,
  output logic            pad_oen,
  output logic            pad_ien,
  output logic            pad_od,
  input  logic            pad_id,
  output logic            id_sync,
  output logic            busy
`ifdef PAD_DIR_ARB_TIMEOUT_EN
  ,
  output logic            timeout_pulse
`endif
);

  // Elaboration-time parameter range checks.
  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("pad_dir_arb: NREQ must be in 2..8");
  end
  if (TURN_CYC < TURN_CYC_MIN || TURN_CYC > TURN_CYC_MAX) begin : g_bad_turn
    $error("pad_dir_arb: TURN_CYC must be in 1..15");
  end
  if (SYNC_STG < SYNC_STG_MIN || SYNC_STG > SYNC_STG_MAX) begin : g_bad_sync
    $error("pad_dir_arb: SYNC_STG must be in 2..3");
  end

  localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  arb_state_t           state;
  logic [IDX_W-1:0]     owner;     // winner in TURN_IN, owner in OWN/TURN_DIR/TURN_OUT
  logic [IDX_W-1:0]     ptr;       // round-robin start point
  logic [CNT_W-1:0]     cnt;       // dead-time counter
  logic                 dir_ok;    // owner has already paid the turnaround to drive
  logic [NREQ_MAX-1:0]  req_x;
  logic [NREQ_MAX-1:0]  oe_x;
  logic [NREQ_MAX-1:0]  od_x;
  logic [NREQ_MAX-1:0]  req_elig;
  logic [NREQ-1:0]      owner_oh;
  logic                 force_out;

  // Widen the per-function vectors to the package maximum so they can be
  // indexed by the fixed-width owner index.
  always_comb begin
    // NOTE: default everything first, then overwrite the live bits; no path leaves a latch.
    req_x = '0;
    oe_x  = '0;
    od_x  = '0;
    req_x[NREQ-1:0] = req;
    oe_x[NREQ-1:0]  = oe_req;
    od_x[NREQ-1:0]  = od_in;
  end

  // One-hot form of the owner index, used to drive grant.
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      owner_oh[i] = (owner == IDX_W'(i));
    end
  end

`ifdef PAD_DIR_ARB_TIMEOUT_EN
  localparam int             OWN_W    = ($clog2(MAX_OWN + 1) > 8) ? $clog2(MAX_OWN + 1) : 8;
  localparam logic [OWN_W-1:0] OWN_LAST = OWN_W'(MAX_OWN - 1);
  localparam logic [OWN_W-1:0] OWN_ONE  = OWN_W'(1);

  if (MAX_OWN < 2) begin : g_bad_max_own
    $error("pad_dir_arb: MAX_OWN must be at least 2");
  end

  logic [OWN_W-1:0]    own_cnt;   // owned cycles so far, saturating at MAX_OWN-1
  logic [NREQ_MAX-1:0] blocked;   // timed-out owners waiting to drop req

  assign req_elig = req_x & ~blocked;

  // Evict the owner once its budget is spent and someone else is waiting.
  always_comb begin
    force_out = (state == OWN || state == TURN_DIR) && (own_cnt >= OWN_LAST) &&
                req_x[owner] && (|(req_elig[NREQ-1:0] & ~owner_oh));
  end
`else
  assign req_elig  = req_x;
  assign force_out = 1'b0;
`endif

  // Arbitration and pad-direction state machine; every output is a flop here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      cnt     <= '0;
      dir_ok  <= 1'b0;
      grant   <= '0;
      pad_oen <= 1'b1;
      pad_ien <= 1'b1;
      pad_od  <= 1'b0;
      busy    <= 1'b0;
`ifdef PAD_DIR_ARB_TIMEOUT_EN
      own_cnt       <= '0;
      blocked       <= '0;
      timeout_pulse <= 1'b0;
`endif
    end else begin
`ifdef PAD_DIR_ARB_TIMEOUT_EN
      timeout_pulse <= 1'b0;
      blocked       <= blocked & req_x;
      if ((state == OWN || state == TURN_DIR) && own_cnt < OWN_LAST) begin
        own_cnt <= own_cnt + OWN_ONE;
      end
`endif
      case (state)
        IDLE: begin
          if (|req_elig) begin
            // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
            owner   <= rr_pick(req_elig, ptr, NREQ);
            cnt     <= TURN_LD;
            pad_ien <= 1'b0;
            busy    <= 1'b1;
            state   <= TURN_IN;
          end
        end

        TURN_IN: begin
          if (!req_x[owner]) begin
            // Winner gave up before ownership started; pointer stays put.
            state   <= IDLE;
            pad_ien <= 1'b1;
            busy    <= 1'b0;
          end else if (cnt == CNT_ONE) begin
            state  <= OWN;
            grant  <= owner_oh;
            dir_ok <= 1'b1;
`ifdef PAD_DIR_ARB_TIMEOUT_EN
            own_cnt <= '0;
`endif
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        OWN, TURN_DIR: begin
          if (!req_x[owner] || force_out) begin
            state   <= TURN_OUT;
            cnt     <= TURN_LD;
            grant   <= '0;
            pad_oen <= 1'b1;
            pad_od  <= 1'b0;
`ifdef PAD_DIR_ARB_TIMEOUT_EN
            if (force_out) begin
              timeout_pulse  <= 1'b1;
              blocked[owner] <= 1'b1;
            end
`endif
          end else if (state == TURN_DIR) begin
            if (cnt == CNT_ONE) begin
              state   <= OWN;
              dir_ok  <= 1'b1;
              pad_oen <= ~oe_x[owner];
              pad_od  <= oe_x[owner] & od_x[owner];
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end else if (!oe_x[owner]) begin
            // Output-to-input needs no dead time: release the driver at once.
            pad_oen <= 1'b1;
            pad_od  <= 1'b0;
            dir_ok  <= 1'b0;
          end else if (dir_ok) begin
            pad_oen <= 1'b0;
            pad_od  <= od_x[owner];
          end else begin
            // Input-to-output: hold the driver off while the pad settles.
            state   <= TURN_DIR;
            cnt     <= TURN_LD;
            pad_oen <= 1'b1;
            pad_od  <= 1'b0;
          end
        end

        TURN_OUT: begin
          if (cnt == CNT_ONE) begin
            state   <= IDLE;
            pad_ien <= 1'b1;
            busy    <= 1'b0;
            ptr     <= (owner == LAST_IDX) ? '0 : owner + IDX_ONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          state   <= IDLE;
          grant   <= '0;
          pad_oen <= 1'b1;
          pad_ien <= 1'b1;
          pad_od  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  pad_in_sync #(
    .STG (SYNC_STG)
  ) u_in_sync (
    .clk (clk),
    .rst (rst),
    .en  (~pad_ien),
    .d   (pad_id),
    .q   (id_sync)
  );

endmodule

// File: doc/pad_dir_arb.md
Name: pad_dir_arb

Overview:
- Shares one bidirectional digital pad (OEN/IEN/OD/ID/PAD cell) between NREQ peripheral functions.
- Grants ownership round-robin and inserts dead-time between owners and on input-to-output turnaround, so no two drivers ever overlap.
- Returns a synchronized pad input to the owner.
- Sits between the peripheral function mux and the pad ring cell.

Parameters:
- NREQ, 2, number of requesting functions (2..8).
- TURN_CYC, 2, dead-time cycles with the driver off (1..15).
- SYNC_STG, 2, input synchronizer depth (2..3).

Ports:
- clk  in  1  block clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-function ownership request, level, held while owning.
- oe_req  in  NREQ  per-function drive request: 1 = drive pad, 0 = input.
- od_in  in  NREQ  per-function output data.
- grant  out  NREQ  one-hot owner indication; all zero when unowned.
- pad_oen  out  1  to pad OEN; active-low output enable.
- pad_ien  out  1  to pad IEN; active-low input enable.
- pad_od  out  1  to pad OD.
- pad_id  in  1  from pad ID.
- id_sync  out  1  synchronized pad input.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE, grant 0, pad_oen 1, pad_ien 1, pad_od 0, id_sync 0, busy 0, RR pointer 0.
- All outputs are registered.
- State IDLE:
  - pad_oen=1, pad_ien=1.
  - If any req is high, pick the winner: the first requester at or after the RR pointer.
  - Load the dead-time counter with TURN_CYC and go to TURN_IN.
- State TURN_IN:
  - pad_oen=1, pad_ien=0, grant=0.
  - Counter decrements each cycle. At 1, go to OWN and assert grant[winner].
  - Timing: req sampled at cycle N gives grant at cycle N+TURN_CYC+1.
- State OWN:
  - grant one-hot. pad_ien=0. pad_oen=~oe_req[owner] registered. pad_od=od_in[owner] registered, 1-cycle latency.
  - oe_req 1→0: pad_oen goes to 1 next cycle, no dead time.
  - oe_req 0→1: go to TURN_DIR for TURN_CYC cycles (pad_oen=1, grant held), then back to OWN driving.
  - req[owner]=0: go to TURN_OUT. grant drops next cycle, pad_oen=1.
- State TURN_OUT:
  - pad_oen=1, grant=0, for TURN_CYC cycles.
  - Then go to IDLE. RR pointer becomes owner+1, wrapping modulo NREQ.
  - A pending req enters TURN_IN from IDLE the next cycle; the extra cycle is intentional.
- Drop during dead time:
  - req[winner] drops during TURN_IN: abort to IDLE, pointer unchanged.
  - req[owner] drops during TURN_DIR: go to TURN_OUT with the counter reloaded.
- Requests from non-owners are ignored until IDLE. There is no preemption.
- pad_od forced to 0 whenever pad_oen=1.
- id_sync:
  - pad_id passes through SYNC_STG flops; id_sync is the last stage.
  - Stages shift only while pad_ien=0 and hold otherwise, so a floating ID never propagates.
- Asynchronous rst mid-ownership: immediately pad_oen=1 and grant=0. No dead time is required; the pad goes tristate.
- Illegal parameter values are rejected by elaboration-time checks.

Optional Feature:
- Macro: PAD_DIR_ARB_TIMEOUT_EN.
- With the macro:
  - Adds parameter MAX_OWN (default 256) and output timeout_pulse.
  - An 8-bit+ ownership counter counts OWN/TURN_DIR cycles.
  - On reaching MAX_OWN while another req is pending: force TURN_OUT, pulse timeout_pulse for 1 cycle, advance the RR pointer.
  - The owner must drop req before it is eligible again.
- Without the macro: no counter, no port; ownership is unbounded.

Decomposition:
- Shared package pad_arb_pkg holds:
  - state enum IDLE/TURN_IN/OWN/TURN_DIR/TURN_OUT;
  - RR-pick function;
  - TURN_CYC and SYNC_STG limit constants.
- One natural sub-module: pad_in_sync (enabled multi-stage synchronizer), reused by other pad controllers.

Test Plan:
- NREQ=2, TURN_CYC=2: req[0]=1, oe_req[0]=1, od_in[0]=1 at cycle 0 → pad_oen=1 in cycles 1–2, grant=01 at cycle 3, pad_oen=0 and pad_od=1 at cycle 4.
- Owner 0 drops req at cycle 10 while req[1] is pending → grant=00 at 11, pad_oen=1 for cycles 11–12, IDLE at 13, grant=10 at 16; pad_oen and pad_od never drive during 11–15.
- Owner 0 toggles oe_req 0→1 → pad_oen stays 1 for 2 cycles and grant stays 01; a 1→0 toggle gives pad_oen=1 on the next cycle.
- req[0] and req[1] held continuously with owners cycling → grant alternates 01,10,01; no starvation.
- pad_id toggles while pad_ien=1 → id_sync unchanged; in OWN, a pad_id edge reaches id_sync after SYNC_STG cycles.
- Assert rst during OWN with pad_oen=0 → pad_oen=1, grant=0, id_sync=0 immediately. With TIMEOUT_EN and MAX_OWN=8, holding req[0] while req[1] is pending → timeout_pulse after 8 owned cycles.
